// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_arb_pkg;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

  typedef enum logic {
    ARB   = 1'b0,
    FORCE = 1'b1
  } arb_state_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus bundle: pipeline WB, multi-cycle unit, decode checks and RF write port.
interface regfile_wb_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  logic                 pipe_wb_en;
  logic [REG_IDX_W-1:0] pipe_wb_addr;
  logic [XLEN-1:0]      pipe_wb_data;
  logic                 ext_valid;
  logic [REG_IDX_W-1:0] ext_addr;
  logic [XLEN-1:0]      ext_data;
  logic                 ext_ready;
  logic                 ext_issue_valid;
  logic [REG_IDX_W-1:0] ext_issue_rd;
  logic                 pipe_stall;
  logic                 rf_write_enable;
  logic [REG_IDX_W-1:0] rf_write_address;
  logic [XLEN-1:0]      rf_write_data;
  logic [REG_IDX_W-1:0] chk_rs_a;
  logic [REG_IDX_W-1:0] chk_rs_b;
  logic [REG_IDX_W-1:0] chk_rd;
  logic                 hazard;
  logic [NREG-1:0]      busy_vec;

  modport slave (
    input  pipe_wb_en, pipe_wb_addr, pipe_wb_data,
    input  ext_valid, ext_addr, ext_data, ext_issue_valid, ext_issue_rd,
    input  chk_rs_a, chk_rs_b, chk_rd,
    output ext_ready, pipe_stall, rf_write_enable, rf_write_address, rf_write_data,
    output hazard, busy_vec
  );

  modport master (
    output pipe_wb_en, pipe_wb_addr, pipe_wb_data,
    output ext_valid, ext_addr, ext_data, ext_issue_valid, ext_issue_rd,
    output chk_rs_a, chk_rs_b, chk_rd,
    input  ext_ready, pipe_stall, rf_write_enable, rf_write_address, rf_write_data,
    input  hazard, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard for ops in flight in the multi-cycle unit.
module regfile_scoreboard
  import wb_arb_pkg::*;
#(
  parameter int NREG = 32
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_valid,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_valid,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] chk_a,
  input  logic [REG_IDX_W-1:0] chk_b,
  input  logic [REG_IDX_W-1:0] chk_c,
  output logic                 hazard,
  output logic [NREG-1:0]      busy_vec
);
  logic [NREG-1:0] busy_q, busy_n;

  function automatic logic is_busy(logic [NREG-1:0] v, logic [REG_IDX_W-1:0] i);
    return (i != X0_IDX) && (int'(i) < NREG) && v[i];
  endfunction

  // Next busy vector: clear first so a same-cycle issue to that index wins.
  always_comb begin
    busy_n = busy_q;
    if (clr_valid && clr_idx != X0_IDX && int'(clr_idx) < NREG) busy_n[clr_idx] = 1'b0;
    if (set_valid && set_idx != X0_IDX && int'(set_idx) < NREG) busy_n[set_idx] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // Busy register.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_n;
  end

  assign hazard   = is_busy(busy_q, chk_a) | is_busy(busy_q, chk_b) | is_busy(busy_q, chk_c);
  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, the multi-cycle
// unit is forced through after STARVE_LIMIT blocked cycles by stalling the
// pipeline for one cycle. Optional perf counters under WB_ARB_PERF_EN.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32,
  parameter int NREG         = 32
)(
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]          conflict_cnt,
  output logic [15:0]          force_cnt
`endif
);
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  arb_state_t      state, state_n;
  logic [3:0]      starve_cnt, cnt_n;
  logic            stall_q, stall_n;
  logic            pipe_req, grant_pipe, grant_ext, ext_wr;
  logic [XLEN-1:0] wr_data;

  assign pipe_req = bus.pipe_wb_en && (bus.pipe_wb_addr != X0_IDX);

  // Grant selection and starvation/FORCE next-state.
  always_comb begin
    state_n    = state;
    cnt_n      = '0;
    stall_n    = 1'b0;
    grant_pipe = 1'b0;
    grant_ext  = 1'b0;
    case (state)
      ARB: begin
        if (pipe_req)           grant_pipe = 1'b1;
        else if (bus.ext_valid) grant_ext  = 1'b1;
        if (bus.ext_valid && !grant_ext) begin
          if (starve_cnt == LIMIT_M1) begin
            state_n = FORCE;
            stall_n = 1'b1;
          end else begin
            cnt_n = starve_cnt + 4'd1;
          end
        end
      end
      FORCE: begin
        // Pipeline is frozen holding its request; only ext may write.
        grant_ext = bus.ext_valid;
        state_n   = ARB;
      end
      default: state_n = ARB;
    endcase
  end

  // FSM, starvation counter and registered stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= cnt_n;
      stall_q    <= stall_n;
    end
  end

  assign ext_wr               = grant_ext && (bus.ext_addr != X0_IDX);
  assign wr_data              = grant_pipe ? bus.pipe_wb_data : bus.ext_data;
  assign bus.ext_ready        = grant_ext;
  assign bus.pipe_stall       = stall_q;
  assign bus.rf_write_enable  = grant_pipe | ext_wr;
  assign bus.rf_write_address = grant_pipe ? bus.pipe_wb_addr : bus.ext_addr;
  assign bus.rf_write_data    = wr_data;

  regfile_scoreboard #(.NREG(NREG)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_valid (bus.ext_issue_valid),
    .set_idx   (bus.ext_issue_rd),
    .clr_valid (ext_wr),
    .clr_idx   (bus.ext_addr),
    .chk_a     (bus.chk_rs_a),
    .chk_b     (bus.chk_rs_b),
    .chk_c     (bus.chk_rd),
    .hazard    (bus.hazard),
    .busy_vec  (bus.busy_vec)
  );

`ifdef WB_ARB_PERF_EN
  // Saturating conflict and FORCE-entry counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= '0;
      force_cnt    <= '0;
    end else begin
      if (bus.ext_valid && !grant_ext && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 32'd1;
      if (state == ARB && state_n == FORCE && force_cnt != '1) force_cnt <= force_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: each row drives one cycle of
// stimulus, pushes the hand-derived expected outputs, and pops/compares them
// at the falling edge of that cycle.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(32), .NREG(32)) bus ();

`ifdef WB_ARB_PERF_EN
  logic [31:0] conflict_cnt;
  logic [15:0] force_cnt;
`endif

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .XLEN(32), .NREG(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef WB_ARB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt),
    .force_cnt    (force_cnt)
`endif
  );

  typedef struct packed {
    logic        rst;
    logic        pen;
    logic [4:0]  paddr;
    logic [31:0] pdata;
    logic        ev;
    logic [4:0]  eaddr;
    logic [31:0] edata;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  ca;
    logic [4:0]  cb;
    logic [4:0]  cd;
  } stim_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic        stall;
    logic        hz;
    logic [31:0] busy;
  } obs_t;

  obs_t scb [$];
  int   checks = 0;
  int   errors = 0;

  function automatic stim_t S(logic rst, logic pen, logic [4:0] paddr, logic [31:0] pdata,
                              logic ev, logic [4:0] eaddr, logic [31:0] edata,
                              logic iv, logic [4:0] ird,
                              logic [4:0] ca, logic [4:0] cb, logic [4:0] cd);
    stim_t s;
    s = '{rst, pen, paddr, pdata, ev, eaddr, edata, iv, ird, ca, cb, cd};
    return s;
  endfunction

  // Address/data only matter when a write is expected.
  function automatic obs_t E(logic en, logic [4:0] addr, logic [31:0] data,
                             logic rdy, logic stall, logic hz, logic [31:0] busy);
    obs_t e;
    e = '{en, en ? addr : 5'd0, en ? data : 32'd0, rdy, stall, hz, busy};
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{bus.rf_write_enable,
          bus.rf_write_enable ? bus.rf_write_address : 5'd0,
          bus.rf_write_enable ? bus.rf_write_data : 32'd0,
          bus.ext_ready, bus.pipe_stall, bus.hazard, bus.busy_vec};
    return o;
  endfunction

  task automatic apply(input stim_t s);
    reset               = s.rst;
    bus.pipe_wb_en      = s.pen;
    bus.pipe_wb_addr    = s.paddr;
    bus.pipe_wb_data    = s.pdata;
    bus.ext_valid       = s.ev;
    bus.ext_addr        = s.eaddr;
    bus.ext_data        = s.edata;
    bus.ext_issue_valid = s.iv;
    bus.ext_issue_rd    = s.ird;
    bus.chk_rs_a        = s.ca;
    bus.chk_rs_b        = s.cb;
    bus.chk_rd          = s.cd;
  endtask

  localparam stim_t IDLE = '0;

  task automatic test_reset();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, want;
    st.push_back(S(1, 0,0,0, 0,0,0, 0,0, 0,0,0));          ex.push_back(E(0,0,0, 0,0,0,0));
    st.push_back(S(0, 0,0,0, 0,0,0, 0,0, 0,5,0));          ex.push_back(E(0,0,0, 0,0,0,0));
    foreach (st[i]) begin
      apply(st[i]); scb.push_back(ex[i]); #4;
      got = sample(); want = scb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset row%0d got=%h exp=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_pipe_write();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, want;
    st.push_back(S(0, 1,5,32'hA5, 0,0,0, 0,0, 0,0,0));     ex.push_back(E(1,5,32'hA5, 0,0,0,0));
    st.push_back(S(0, 1,0,32'h77, 0,0,0, 0,0, 0,0,0));     ex.push_back(E(0,0,0, 0,0,0,0));
    st.push_back(S(0, 1,31,32'hFFFF_0001, 0,0,0, 0,0, 0,0,0)); ex.push_back(E(1,31,32'hFFFF_0001, 0,0,0,0));
    foreach (st[i]) begin
      apply(st[i]); scb.push_back(ex[i]); #4;
      got = sample(); want = scb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pipe_write row%0d got=%h exp=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ext_grant();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, want;
    st.push_back(S(0, 1,0,32'h1, 1,7,32'h1234, 0,0, 0,0,0)); ex.push_back(E(1,7,32'h1234, 1,0,0,0));
    st.push_back(S(0, 0,0,0,     1,0,32'h55,   0,0, 0,0,0)); ex.push_back(E(0,0,0, 1,0,0,0));
    st.push_back(S(0, 0,0,0,     1,8,32'hCAFE, 0,0, 0,0,0)); ex.push_back(E(1,8,32'hCAFE, 1,0,0,0));
    foreach (st[i]) begin
      apply(st[i]); scb.push_back(ex[i]); #4;
      got = sample(); want = scb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL ext_grant row%0d got=%h exp=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_starve();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, want;
    // Ext blocked four cycles, forced in on the fifth, held pipe write on the sixth.
    for (int k = 1; k <= 4; k++) begin
      st.push_back(S(0, 1,5'(k),32'(k*17), 1,12,32'hBEEF, 0,0, 0,0,0));
      ex.push_back(E(1,5'(k),32'(k*17), 0,0,0,0));
    end
    st.push_back(S(0, 1,5,32'h55, 1,12,32'hBEEF, 0,0, 0,0,0)); ex.push_back(E(1,12,32'hBEEF, 1,1,0,0));
    st.push_back(S(0, 1,5,32'h55, 0,0,0,         0,0, 0,0,0)); ex.push_back(E(1,5,32'h55, 0,0,0,0));
    // Ext gives up before FORCE: stall still happens, no write, pipe ignored.
    for (int k = 0; k < 4; k++) begin
      st.push_back(S(0, 1,6,32'h66, 1,13,32'h13, 0,0, 0,0,0));
      ex.push_back(E(1,6,32'h66, 0,0,0,0));
    end
    st.push_back(S(0, 1,6,32'h66, 0,0,0, 0,0, 0,0,0)); ex.push_back(E(0,0,0, 0,1,0,0));
    st.push_back(S(0, 1,6,32'h66, 0,0,0, 0,0, 0,0,0)); ex.push_back(E(1,6,32'h66, 0,0,0,0));
    foreach (st[i]) begin
      apply(st[i]); scb.push_back(ex[i]); #4;
      got = sample(); want = scb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL starve row%0d got=%h exp=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_scoreboard();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, want;
    st.push_back(S(0, 0,0,0, 0,0,0,        1,9,  0,9,0));   ex.push_back(E(0,0,0, 0,0,0,0));
    st.push_back(S(0, 0,0,0, 0,0,0,        0,0,  0,9,0));   ex.push_back(E(0,0,0, 0,0,1,32'h200));
    st.push_back(S(0, 0,0,0, 1,9,32'h99,   0,0,  0,9,0));   ex.push_back(E(1,9,32'h99, 1,0,1,32'h200));
    st.push_back(S(0, 0,0,0, 0,0,0,        0,0,  0,9,0));   ex.push_back(E(0,0,0, 0,0,0,0));
    st.push_back(S(0, 0,0,0, 0,0,0,        1,17, 0,0,0));   ex.push_back(E(0,0,0, 0,0,0,0));
    st.push_back(S(0, 0,0,0, 0,0,0,        0,0,  17,0,0));  ex.push_back(E(0,0,0, 0,0,1,32'h2_0000));
    st.push_back(S(0, 1,17,32'h3, 0,0,0,   0,0,  0,0,17));  ex.push_back(E(1,17,32'h3, 0,0,1,32'h2_0000));
    st.push_back(S(0, 0,0,0, 1,17,32'h17,  0,0,  0,0,0));   ex.push_back(E(1,17,32'h17, 1,0,0,32'h2_0000));
    st.push_back(S(0, 0,0,0, 0,0,0,        0,0,  17,0,17)); ex.push_back(E(0,0,0, 0,0,0,0));
    foreach (st[i]) begin
      apply(st[i]); scb.push_back(ex[i]); #4;
      got = sample(); want = scb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL scoreboard row%0d got=%h exp=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_set_wins();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, want;
    st.push_back(S(0, 0,0,0, 0,0,0,      1,9, 0,0,0));  ex.push_back(E(0,0,0, 0,0,0,0));
    st.push_back(S(0, 0,0,0, 1,9,32'h1,  1,9, 0,0,0));  ex.push_back(E(1,9,32'h1, 1,0,0,32'h200));
    st.push_back(S(0, 0,0,0, 0,0,0,      0,0, 9,0,0));  ex.push_back(E(0,0,0, 0,0,1,32'h200));
    st.push_back(S(0, 0,0,0, 1,9,32'h2,  0,0, 0,0,0));  ex.push_back(E(1,9,32'h2, 1,0,0,32'h200));
    st.push_back(S(0, 0,0,0, 0,0,0,      0,0, 9,0,0));  ex.push_back(E(0,0,0, 0,0,0,0));
    foreach (st[i]) begin
      apply(st[i]); scb.push_back(ex[i]); #4;
      got = sample(); want = scb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL set_wins row%0d got=%h exp=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_force();
    stim_t st [$];
    obs_t  ex [$];
    obs_t  got, want;
    st.push_back(S(0, 1,1,32'h1, 1,2,32'h2, 1,3, 0,0,0)); ex.push_back(E(1,1,32'h1, 0,0,0,0));
    for (int k = 0; k < 3; k++) begin
      st.push_back(S(0, 1,1,32'h1, 1,2,32'h2, 0,0, 0,0,0)); ex.push_back(E(1,1,32'h1, 0,0,0,32'h8));
    end
    st.push_back(S(1, 1,1,32'h1, 1,2,32'h2, 0,0, 3,0,0)); ex.push_back(E(1,2,32'h2, 1,1,1,32'h8));
    st.push_back(S(0, 0,0,0, 0,0,0, 0,0, 3,0,0));         ex.push_back(E(0,0,0, 0,0,0,0));
    st.push_back(S(0, 0,0,0, 0,0,0, 1,0, 0,0,0));         ex.push_back(E(0,0,0, 0,0,0,0));
    st.push_back(S(0, 0,0,0, 0,0,0, 0,0, 0,0,0));         ex.push_back(E(0,0,0, 0,0,0,0));
    foreach (st[i]) begin
      apply(st[i]); scb.push_back(ex[i]); #4;
      got = sample(); want = scb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset_force row%0d got=%h exp=%h", i, got, want); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply(S(1, 0,0,0, 0,0,0, 0,0, 0,0,0));
    @(posedge clk); #1;
    test_reset();
    test_pipe_write();
    test_ext_grant();
    test_starve();
    test_scoreboard();
    test_set_wins();
    test_reset_force();
    apply(IDLE);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
